// File: rtl/trace_pkt_rx.sv
// Retirement trace packet receiver: compacts up to 3 valid lanes per cycle into a FIFO and drains one per cycle.
// Optional per-entry cycle timestamp enabled by defining TRACE_PKT_RX_TSTAMP_EN.
module trace_pkt_rx #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [2:0]        trace_rv_i_valid_ip,
    input  logic [95:0]       trace_rv_i_insn_ip,
    input  logic [95:0]       trace_rv_i_address_ip,
    input  logic [2:0]        trace_rv_i_exception_ip,
    input  logic [2:0]        trace_rv_i_interrupt_ip,
    input  logic [4:0]        trace_rv_i_ecause_ip,
    input  logic [31:0]       trace_rv_i_tval_ip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [31:0]       out_addr,
    output logic              out_exc,
    output logic              out_intr,
    output logic [4:0]        out_ecause,
    output logic [31:0]       out_tval,
    output logic [15:0]       out_tstamp,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow,
    input  logic              drop_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] insn_mem   [DEPTH];
    logic [31:0] addr_mem   [DEPTH];
    logic        exc_mem    [DEPTH];
    logic        intr_mem   [DEPTH];
    logic [4:0]  ecause_mem [DEPTH];
    logic [31:0] tval_mem   [DEPTH];

    logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [AW:0]       count_reg, count_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic              overflow_reg, overflow_next;
    logic              pop, push_ok, drop;
    logic [1:0]        lane_n;
    logic [AW+1:0]     free;
    logic [1:0]        lane_off  [3];
    logic [AW-1:0]     lane_slot [3];
    logic [31:0]       lane_insn [3];
    logic [31:0]       lane_addr [3];

    assign pop    = (count_reg != '0) & out_ready;
    assign lane_n = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]}
                  + {1'b0, trace_rv_i_valid_ip[2]};

    // A lane's slot is offset by the number of valid lanes below it, which compacts out gaps.
    assign lane_off[0] = 2'd0;
    assign lane_off[1] = {1'b0, trace_rv_i_valid_ip[0]};
    assign lane_off[2] = {1'b0, trace_rv_i_valid_ip[0]} + {1'b0, trace_rv_i_valid_ip[1]};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_slot[gi] = wr_ptr_reg + AW'(lane_off[gi]);
            assign lane_insn[gi] = trace_rv_i_insn_ip[32*gi +: 32];
            assign lane_addr[gi] = trace_rv_i_address_ip[32*gi +: 32];
        end
    endgenerate

    // The core cannot stall, so a packet that does not fit entirely is discarded whole.
    assign free    = (AW+2)'(DEPTH) - {1'b0, count_reg} + (AW+2)'(pop);
    assign drop    = (lane_n != 2'd0) && ((AW+2)'(lane_n) > free);
    assign push_ok = (lane_n != 2'd0) && !drop;

    assign count_next = count_reg + (push_ok ? (AW+1)'(lane_n) : '0) - (AW+1)'(pop);

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        overflow_next = overflow_reg;
        if (drop_clr) begin
            drop_cnt_next = '0;
            overflow_next = 1'b0;
        end
        if (drop) begin
            overflow_next = 1'b1;
            if (drop_clr)
                drop_cnt_next = DROP_W'(1);
            else if (drop_cnt_reg != '1)
                drop_cnt_next = drop_cnt_reg + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_reg + AW'(pop);
            wr_ptr_reg   <= wr_ptr_reg + (push_ok ? AW'(lane_n) : '0);
            count_reg    <= count_next;
            drop_cnt_reg <= drop_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (trace_rv_i_valid_ip[i]) begin
                    insn_mem[lane_slot[i]]   <= lane_insn[i];
                    addr_mem[lane_slot[i]]   <= lane_addr[i];
                    exc_mem[lane_slot[i]]    <= trace_rv_i_exception_ip[i];
                    intr_mem[lane_slot[i]]   <= trace_rv_i_interrupt_ip[i];
                    ecause_mem[lane_slot[i]] <= trace_rv_i_ecause_ip;
                    tval_mem[lane_slot[i]]   <= trace_rv_i_tval_ip;
                end
            end
        end
    end

    assign out_valid  = (count_reg != '0);
    assign out_insn   = out_valid ? insn_mem[rd_ptr_reg]   : '0;
    assign out_addr   = out_valid ? addr_mem[rd_ptr_reg]   : '0;
    assign out_exc    = out_valid ? exc_mem[rd_ptr_reg]    : 1'b0;
    assign out_intr   = out_valid ? intr_mem[rd_ptr_reg]   : 1'b0;
    assign out_ecause = out_valid ? ecause_mem[rd_ptr_reg] : '0;
    assign out_tval   = out_valid ? tval_mem[rd_ptr_reg]   : '0;
    assign drop_cnt   = drop_cnt_reg;
    assign overflow   = overflow_reg;

`ifdef TRACE_PKT_RX_TSTAMP_EN
    logic [15:0] tstamp_reg;
    logic [15:0] tstamp_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            tstamp_reg <= '0;
        else
            tstamp_reg <= tstamp_reg + 16'd1;
    end

    // Every lane of a packet shares the cycle stamp of its push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (trace_rv_i_valid_ip[i])
                    tstamp_mem[lane_slot[i]] <= tstamp_reg;
            end
        end
    end

    assign out_tstamp = out_valid ? tstamp_mem[rd_ptr_reg] : '0;
`else
    assign out_tstamp = '0;
`endif
endmodule

// File: tb/tb_trace_pkt_rx.sv
// Self-checking bench for trace_pkt_rx: table-driven packets, scoreboard of expected FIFO entries.
// Timestamp checks follow TRACE_PKT_RX_TSTAMP_EN.
module tb_trace_pkt_rx;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [2:0]  valid_ip;
    logic [95:0] insn_ip;
    logic [95:0] addr_ip;
    logic [2:0]  exc_ip;
    logic [2:0]  intr_ip;
    logic [4:0]  ecause_ip;
    logic [31:0] tval_ip;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_addr;
    logic        out_exc;
    logic        out_intr;
    logic [4:0]  out_ecause;
    logic [31:0] out_tval;
    logic [15:0] out_tstamp;
    logic [DROP_W-1:0] drop_cnt;
    logic        overflow;
    logic        drop_clr;

    trace_pkt_rx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .trace_rv_i_valid_ip     (valid_ip),
        .trace_rv_i_insn_ip      (insn_ip),
        .trace_rv_i_address_ip   (addr_ip),
        .trace_rv_i_exception_ip (exc_ip),
        .trace_rv_i_interrupt_ip (intr_ip),
        .trace_rv_i_ecause_ip    (ecause_ip),
        .trace_rv_i_tval_ip      (tval_ip),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_insn                (out_insn),
        .out_addr                (out_addr),
        .out_exc                 (out_exc),
        .out_intr                (out_intr),
        .out_ecause              (out_ecause),
        .out_tval                (out_tval),
        .out_tstamp              (out_tstamp),
        .drop_cnt                (drop_cnt),
        .overflow                (overflow),
        .drop_clr                (drop_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  v;
        logic [95:0] insn;
        logic [95:0] addr;
        logic [2:0]  exc;
        logic [2:0]  intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic        rdy;
        logic        clr;
        logic [15:0] exp_drop;
        logic        exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [31:0] tval;
        logic [15:0] tstamp;
    } exp_t;

    exp_t q[$];
    int   m_count;
    int   n_checks;
    int   n_fail;
    logic [31:0] tb_cyc;
    vec_t tbl [24];

`ifdef TRACE_PKT_RX_TSTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Mirrors the free-running cycle counter the DUT stamps entries with.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic logic [95:0] lanes(input logic [31:0] base);
        return {base + 32'd2, base + 32'd1, base};
    endfunction

    function automatic vec_t mk(input logic [2:0] v, input logic [95:0] insn, input logic [95:0] addr,
                                input logic [2:0] exc, input logic [2:0] intr, input logic [4:0] ec,
                                input logic [31:0] tval, input logic rdy, input logic clr,
                                input logic [15:0] exp_drop, input logic exp_ovf);
        vec_t t;
        t.v = v; t.insn = insn; t.addr = addr; t.exc = exc; t.intr = intr; t.ecause = ec;
        t.tval = tval; t.rdy = rdy; t.clr = clr; t.exp_drop = exp_drop; t.exp_ovf = exp_ovf;
        return t;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply_vec(input vec_t t);
        logic pop;
        int   n, free;
        exp_t e, h;
        valid_ip = t.v; insn_ip = t.insn; addr_ip = t.addr; exc_ip = t.exc; intr_ip = t.intr;
        ecause_ip = t.ecause; tval_ip = t.tval; out_ready = t.rdy; drop_clr = t.clr;
        #1;
        check("out_valid", 64'(out_valid), 64'(m_count != 0));
        pop = (m_count != 0) && t.rdy;
        if (out_valid && q.size() != 0) begin
            h = q[0];
            check("head_insn", 64'(out_insn), 64'(h.insn));
            check("head_addr", 64'(out_addr), 64'(h.addr));
            check("head_flags", 64'({out_exc, out_intr, out_ecause}), 64'({h.exc, h.intr, h.ecause}));
            check("head_tval", 64'(out_tval), 64'(h.tval));
            check("head_tstamp", 64'(out_tstamp), 64'(h.tstamp));
        end else if (!out_valid) begin
            check("gated_data", 64'(out_insn | out_addr | out_tval | 32'(out_ecause) | 32'(out_tstamp)
                  | 32'(out_exc) | 32'(out_intr)), 64'd0);
        end
        if (pop && q.size() != 0) void'(q.pop_front());
        n    = $countones(t.v);
        free = DEPTH - m_count + (pop ? 1 : 0);
        if (n != 0 && n <= free) begin
            for (int i = 0; i < 3; i++) begin
                if (t.v[i]) begin
                    e.insn   = t.insn[32*i +: 32];
                    e.addr   = t.addr[32*i +: 32];
                    e.exc    = t.exc[i];
                    e.intr   = t.intr[i];
                    e.ecause = t.ecause;
                    e.tval   = t.tval;
                    e.tstamp = TS_EN ? tb_cyc[15:0] : 16'd0;
                    q.push_back(e);
                end
            end
            m_count = m_count + n;
        end
        if (pop) m_count = m_count - 1;
        @(posedge clk);
        #1;
        check("drop_cnt", 64'(drop_cnt), 64'(t.exp_drop));
        check("overflow", 64'(overflow), 64'(t.exp_ovf));
    endtask

    initial begin
        vec_t idle1, idle0, t;
        n_checks = 0; n_fail = 0; m_count = 0;
        rst_l = 1'b0; valid_ip = '0; insn_ip = '0; addr_ip = '0; exc_ip = '0; intr_ip = '0;
        ecause_ip = '0; tval_ip = '0; out_ready = 1'b0; drop_clr = 1'b0;

        idle1 = mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0, 16'd0, 1'b0);
        idle0 = mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 16'd0, 1'b0);
        tbl[0]  = mk(3'b111, {32'h33, 32'h22, 32'h11}, lanes(32'h100), 3'b000, 3'b000, 5'd0, 32'd0, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int i = 1; i <= 4; i++) tbl[i] = idle1;
        tbl[5]  = mk(3'b101, {32'hA2, 32'h0, 32'hA0}, {32'h1008, 32'h0, 32'h1000}, 3'b001, 3'b100, 5'h2, 32'hDEAD, 1'b0, 1'b0, 16'd0, 1'b0);
        tbl[6]  = idle1;
        tbl[7]  = idle1;
        tbl[8]  = mk(3'b111, lanes(32'h200), lanes(32'h2000), 3'b010, 3'b000, 5'd3, 32'd1, 1'b0, 1'b0, 16'd0, 1'b0);
        tbl[9]  = mk(3'b111, lanes(32'h300), lanes(32'h3000), 3'b000, 3'b001, 5'd4, 32'd2, 1'b0, 1'b0, 16'd0, 1'b0);
        tbl[10] = mk(3'b111, lanes(32'h400), lanes(32'h4000), 3'b000, 3'b000, 5'd5, 32'd3, 1'b0, 1'b0, 16'd1, 1'b1);
        tbl[11] = mk(3'b011, lanes(32'h500), lanes(32'h5000), 3'b000, 3'b000, 5'd6, 32'd4, 1'b0, 1'b0, 16'd1, 1'b1);
        tbl[12] = mk(3'b001, lanes(32'h600), lanes(32'h6000), 3'b000, 3'b000, 5'd7, 32'd5, 1'b1, 1'b0, 16'd1, 1'b1);
        tbl[13] = mk(3'b110, lanes(32'h700), lanes(32'h7000), 3'b000, 3'b000, 5'd8, 32'd6, 1'b1, 1'b0, 16'd2, 1'b1);
        tbl[14] = mk(3'b111, lanes(32'h800), lanes(32'h8000), 3'b000, 3'b000, 5'd9, 32'd7, 1'b0, 1'b1, 16'd1, 1'b1);
        tbl[15] = mk(3'b000, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 16'd0, 1'b0);
        for (int i = 16; i < 24; i++) tbl[i] = idle1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_tstamp", 64'(out_tstamp), 64'd0);
        rst_l = 1'b1;

        for (int i = 0; i < 24; i++) apply_vec(tbl[i]);
        check("fifo_empty_after_table", 64'(q.size()), 64'd0);

        // Fill, force a drop, then reset mid-operation.
        apply_vec(mk(3'b111, lanes(32'h900), lanes(32'h9000), 3'b0, 3'b0, 5'd1, 32'd9, 1'b0, 1'b0, 16'd0, 1'b0));
        apply_vec(mk(3'b111, lanes(32'hA00), lanes(32'hA000), 3'b0, 3'b0, 5'd1, 32'd9, 1'b0, 1'b0, 16'd0, 1'b0));
        apply_vec(mk(3'b111, lanes(32'hB00), lanes(32'hB000), 3'b0, 3'b0, 5'd1, 32'd9, 1'b0, 1'b0, 16'd1, 1'b1));
        valid_ip = '0;
        rst_l = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_insn", 64'(out_insn), 64'd0);
        q.delete();
        m_count = 0;
        @(posedge clk);
        #1;
        rst_l = 1'b1;

        // Timestamp: push at cycle 5 after reset, and (when stamping) at cycle 0x10004.
        while (tb_cyc != 32'd5) begin
            @(posedge clk);
            #1;
        end
        apply_vec(mk(3'b001, lanes(32'hC00), lanes(32'hC000), 3'b0, 3'b0, 5'd0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0));
        if (TS_EN) begin
            valid_ip = '0;
            while (tb_cyc != 32'h10004) begin
                @(posedge clk);
                #1;
            end
            apply_vec(mk(3'b001, lanes(32'hD00), lanes(32'hD000), 3'b0, 3'b0, 5'd0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0));
        end
        t = idle1;
        apply_vec(t);
        apply_vec(t);
        apply_vec(t);
        apply_vec(idle0);
        check("fifo_empty_at_end", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
